braille_msg_scroller: RTL
=========================

Name: braille_msg_scroller

Overview:
Parametrised successor to the single-cell braille-to-7-segment decoder.
- Captures one 6-dot braille cell from SW on each debounced KEY press.
- Validates the cell against the full grade-1 a–z table, including w, and stores it in a DEPTH-entry message buffer.
- Shows the message across NUM_DIGITS seven-segment displays, either static or as a continuous scrolling marquee.
- Sits directly on the board I/O (CLOCK_50, SW, KEY, HEXn).

Parameters:
- DEPTH, 16, number of stored characters; must be ≥ 2.
- NUM_DIGITS, 4, number of seven-segment digits driven.
- CLK_HZ, 50_000_000, CLOCK_50 frequency.
- SCROLL_HZ, 2, marquee shift rate.
- DEBOUNCE_CYCLES, 1_000_000, stable cycles required to accept a key level (20 ms).

Ports:
- CLOCK_50  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- SW  in  6  braille dots; SW[0]=dot1 … SW[5]=dot6; 1 = raised.
- store_n  in  1  KEY, active-low, asynchronous to the clock; press stores the current cell.
- clear_n  in  1  KEY, active-low; press empties the buffer.
- scroll_en  in  1  level input; 1 = marquee mode.
- HEX  out  7*NUM_DIGITS  active-low segments; digit k = HEX[7k+6:7k], bit0=a … bit6=g; digit 0 is rightmost.
- count  out  $clog2(DEPTH+1)  number of stored characters.
- full  out  1  count == DEPTH.
- invalid  out  1  sticky: the last store attempt used an unassigned pattern.

Behaviour:
- Reset (async assert, sync release):
  - count=0, full=0, invalid=0, HEX all 1 (blank).
  - Scroll offset=0, prescaler=0, state=EMPTY.
  - Sync flops=1 (released), debounce counters=0.
- Key path:
  - Each KEY goes through a 2-flop synchroniser, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical samples.
  - Each accepted 1→0 transition produces exactly one 1-cycle pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Decode: combinational lookup of SW to a 5-bit code.
  - 0–25 = a–z (grade-1 dots: a=1, b=12, c=14 … w=2456 … z=1356).
  - 26 = space (all dots 0).
  - Any other pattern is unassigned.
- Store pulse, evaluated in the same cycle as the pulse:
  - Unassigned pattern: invalid←1, no write.
  - Else if full: ignored, no flag change.
  - Else: buf[count]←code, count←count+1, invalid←0.
- Clear pulse: count←0, invalid←0, offset←0. Clear beats store when both pulse in the same cycle.
- Display model: virtual sequence V of length count+1, V[j]=buf[j] for j<count, V[count]=blank.
- FSM states and transitions:
  - EMPTY: count==0. All digits blank. Go to STATIC on the first store.
  - STATIC: count>0 and (scroll_en==0 or count<NUM_DIGITS).
    - Shows the last min(count, NUM_DIGITS) characters right-aligned, newest on digit 0, remaining digits blank.
  - SCROLL: count≥NUM_DIGITS and scroll_en==1.
    - Digit (NUM_DIGITS-1-i) shows V[(offset+i) mod (count+1)].
    - Prescaler counts 0 … CLK_HZ/SCROLL_HZ-1; on wrap, offset←offset+1.
    - offset wraps from count back to 0.
    - On entry, prescaler←0 and offset←0.
  - Exit SCROLL to STATIC when scroll_en falls: offset←0.
  - Exit to EMPTY on clear, from any state.
  - Store during SCROLL: offset is kept; count grows, so no out-of-range index occurs.
- Latency:
  - count, full and invalid update on the clock edge after the pulse.
  - HEX is registered and updates one cycle after the state/buffer change, i.e. 2 cycles after the pulse.
- Glyph table: 26 letters plus blank (0000000) plus dash (g only).
  - Stored active-high, inverted at the output.
  - 'A' = 1110111 → HEX 0001000. 'b' = 1111100 → HEX 0000011.
  - Dash is shown on digit 0 for one scroll period… no: dash is not shown; invalid is reported only through the invalid output.

Decomposition:
- Package braille_pkg holds:
  - Code width (5) and code constants CODE_SPACE=26.
  - 64-entry dot-pattern→code table with a valid bit.
  - 27-entry code→segment glyph table.
  - FSM state enum {EMPTY, STATIC, SCROLL}.
- Sub-module key_debounce (params DEBOUNCE_CYCLES): synchroniser, stable counter and falling-edge pulse. Instantiated twice (store_n, clear_n).
- Buffer: flop array; DEPTH is small, so no RAM inference is needed.

Test Plan:
Bench parameters: DEPTH=4, NUM_DIGITS=2, DEBOUNCE_CYCLES=4, CLK_HZ=16, SCROLL_HZ=2 (8-cycle scroll period).
1. Assert reset mid-press with count=3 → immediately HEX=14'h3FFF, count=0, full=0, invalid=0; no store once reset releases while the key is still held.
2. SW=6'b000001, store_n low for 6 cycles → count=1; two cycles later HEX[6:0]=0001000, HEX[13:7]=1111111.
3. SW=6'b110000 (dots 5,6, unassigned), store → invalid=1, count unchanged; then a valid store 'b' (SW=6'b000011) → invalid=0, HEX[6:0]=0000011.
4. Store a, b, c, d, then a 5th store → count=4, full=1 after the 4th store; the 5th is ignored and invalid stays 0.
5. Buffer a,b,c with scroll_en=1 → windows (a,b), (b,c), (c,blank), (blank,a), (a,b) every 8 cycles; drop scroll_en → STATIC shows (b,c).
6. store_n low for 3 cycles → no store; store and clear pulsing in the same cycle → count=0, HEX blank.

Source files
------------

// File: rtl/braille_pkg.sv
// Braille cell decode and seven-segment glyph tables
// shared by the message scroller.
package braille_pkg;

    localparam int CODE_W = 5;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t CODE_SPACE = 5'd26;

    typedef struct packed {
        logic  valid;
        code_t code;
    } dec_t;

    typedef enum logic [1:0] {
        EMPTY,
        STATIC,
        SCROLL
    } state_t;

    // Index is the raw dot pattern: bit0 = dot1 ... bit5 = dot6.
    function automatic dec_t braille_decode(
        input logic [5:0] dots
    );
        dec_t d;
        d.valid = 1'b1;
        d.code  = CODE_SPACE;
        case (dots)
            6'h00: d.code = CODE_SPACE;
            6'h01: d.code = 5'd0;
            6'h03: d.code = 5'd1;
            6'h09: d.code = 5'd2;
            6'h19: d.code = 5'd3;
            6'h11: d.code = 5'd4;
            6'h0B: d.code = 5'd5;
            6'h1B: d.code = 5'd6;
            6'h13: d.code = 5'd7;
            6'h0A: d.code = 5'd8;
            6'h1A: d.code = 5'd9;
            6'h05: d.code = 5'd10;
            6'h07: d.code = 5'd11;
            6'h0D: d.code = 5'd12;
            6'h1D: d.code = 5'd13;
            6'h15: d.code = 5'd14;
            6'h0F: d.code = 5'd15;
            6'h1F: d.code = 5'd16;
            6'h17: d.code = 5'd17;
            6'h0E: d.code = 5'd18;
            6'h1E: d.code = 5'd19;
            6'h25: d.code = 5'd20;
            6'h27: d.code = 5'd21;
            6'h3A: d.code = 5'd22;
            6'h2D: d.code = 5'd23;
            6'h3D: d.code = 5'd24;
            6'h35: d.code = 5'd25;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Active-high segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] glyph(
        input code_t c
    );
        logic [6:0] g;
        case (c)
            5'd0:  g = 7'h77;
            5'd1:  g = 7'h7C;
            5'd2:  g = 7'h39;
            5'd3:  g = 7'h5E;
            5'd4:  g = 7'h79;
            5'd5:  g = 7'h71;
            5'd6:  g = 7'h3D;
            5'd7:  g = 7'h76;
            5'd8:  g = 7'h06;
            5'd9:  g = 7'h1E;
            5'd10: g = 7'h75;
            5'd11: g = 7'h38;
            5'd12: g = 7'h37;
            5'd13: g = 7'h54;
            5'd14: g = 7'h5C;
            5'd15: g = 7'h73;
            5'd16: g = 7'h67;
            5'd17: g = 7'h50;
            5'd18: g = 7'h6D;
            5'd19: g = 7'h78;
            5'd20: g = 7'h3E;
            5'd21: g = 7'h1C;
            5'd22: g = 7'h2A;
            5'd23: g = 7'h64;
            5'd24: g = 7'h6E;
            5'd25: g = 7'h5B;
            5'd26: g = 7'h00;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/braille_msg_scroller_if.sv
// Board-side bundle of the scroller: switches, keys,
// mode level and the display/status outputs.
interface braille_msg_scroller_if #(
    parameter int DEPTH      = 16,
    parameter int NUM_DIGITS = 4
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [5:0]              SW;
    logic                    store_n;
    logic                    clear_n;
    logic                    scroll_en;
    logic [7*NUM_DIGITS-1:0] HEX;
    logic [CNT_W-1:0]        count;
    logic                    full;
    logic                    invalid;

    modport master (
        output SW,
        output store_n,
        output clear_n,
        output scroll_en,
        input  HEX,
        input  count,
        input  full,
        input  invalid
    );

    modport slave (
        input  SW,
        input  store_n,
        input  clear_n,
        input  scroll_en,
        output HEX,
        output count,
        output full,
        output invalid
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronises an active-low key, debounces it and emits
// a one-cycle pulse per accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    // Accepted level starts low so a key already held at
    // reset release must be seen released before it counts.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= s2;
                press <= ~s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/braille_msg_scroller.sv
// Braille message buffer with static or marquee display
// across NUM_DIGITS seven-segment digits.
module braille_msg_scroller
    import braille_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int NUM_DIGITS      = 4,
    parameter int CLK_HZ          = 50_000_000,
    parameter int SCROLL_HZ       = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic                   CLOCK_50,
    input logic                   reset,
    braille_msg_scroller_if.slave bus
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int AW     = $clog2(DEPTH);
    localparam int PERIOD = CLK_HZ / SCROLL_HZ;
    localparam int PW     = $clog2(PERIOD + 1);
    localparam logic [PW-1:0] PMAX = PW'(PERIOD - 1);

    logic                    store_p;
    logic                    clear_p;
    dec_t                    dec;
    logic                    full_w;
    logic                    wr_en;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_nxt;
    logic [CNT_W-1:0]        offset_q;
    logic [PW-1:0]           presc_q;
    logic                    invalid_q;
    state_t                  state_q;
    state_t                  state_nxt;
    code_t                   mem_q [DEPTH];
    logic [7*NUM_DIGITS-1:0] hex_q;
    logic [7*NUM_DIGITS-1:0] hex_nxt;
    logic [6:0]              seg;
    int                      idx;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_store (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .key_n   (bus.store_n),
        .press   (store_p)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .key_n   (bus.clear_n),
        .press   (clear_p)
    );

    always_comb begin
        dec       = braille_decode(bus.SW);
        full_w    = (count_q == CNT_W'(DEPTH));
        wr_en     = store_p && !clear_p && dec.valid && !full_w;
        count_nxt = count_q;
        if (clear_p) begin
            count_nxt = '0;
        end else if (wr_en) begin
            count_nxt = count_q + CNT_W'(1);
        end
        if (count_nxt == '0) begin
            state_nxt = EMPTY;
        end else if (bus.scroll_en &&
                     count_nxt >= CNT_W'(NUM_DIGITS)) begin
            state_nxt = SCROLL;
        end else begin
            state_nxt = STATIC;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            invalid_q <= 1'b0;
            state_q   <= EMPTY;
            offset_q  <= '0;
            presc_q   <= '0;
            hex_q     <= '1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_nxt;
            state_q <= state_nxt;
            hex_q   <= hex_nxt;
            if (wr_en) begin
                mem_q[AW'(count_q)] <= dec.code;
            end
            if (clear_p) begin
                invalid_q <= 1'b0;
            end else if (store_p) begin
                if (!dec.valid) begin
                    invalid_q <= 1'b1;
                end else if (!full_w) begin
                    invalid_q <= 1'b0;
                end
            end
            // Any entry to or exit from the marquee restarts it.
            if (state_q != SCROLL || state_nxt != SCROLL) begin
                presc_q  <= '0;
                offset_q <= '0;
            end else if (presc_q == PMAX) begin
                presc_q  <= '0;
                offset_q <= (offset_q >= count_q) ?
                            '0 : offset_q + CNT_W'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // V has count+1 slots; slot count is the trailing blank.
    always_comb begin
        hex_nxt = '1;
        seg     = '0;
        idx     = 0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg = '0;
            idx = 0;
            case (state_q)
                STATIC: begin
                    if (k < int'(count_q)) begin
                        idx = int'(count_q) - 1 - k;
                        seg = glyph(mem_q[AW'(idx)]);
                    end
                end
                SCROLL: begin
                    idx = int'(offset_q) + NUM_DIGITS - 1 - k;
                    if (idx > int'(count_q)) begin
                        idx = idx - int'(count_q) - 1;
                    end
                    if (idx != int'(count_q)) begin
                        seg = glyph(mem_q[AW'(idx)]);
                    end
                end
                default: seg = '0;
            endcase
            hex_nxt[7*k +: 7] = ~seg;
        end
    end

    assign bus.HEX     = hex_q;
    assign bus.count   = count_q;
    assign bus.full    = full_w;
    assign bus.invalid = invalid_q;

endmodule
